// File: rtl/opamp_seq_ctrl.sv
// Wishbone power sequencer for the cascode opamp and its analog pads 12..17.
// Optional RUN-time counter at index 4 when OPAMP_SEQ_RUNCNT_EN is defined.
module opamp_seq_ctrl #(
    parameter logic [31:0]      BASE_ADDR     = 32'h3000_0100,
    parameter int unsigned      DLY_W         = 16,
    parameter logic [DLY_W-1:0] DEFAULT_DELAY = 16'd100
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic [5:0]  pad_oeb_o,
    output logic [1:0]  bias_en_o,
    output logic        ib_en_o,
    output logic        in_en_o,
    output logic        ready_o,
    output logic        irq_o
);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_ISOLATE = 3'd1,
        S_BIAS    = 3'd2,
        S_CURRENT = 3'd3,
        S_INPUTS  = 3'd4,
        S_RUN     = 3'd5,
        S_SD_IN   = 3'd6,
        S_SD_IB   = 3'd7
    } state_e;

    state_e           state_q, state_d;
    logic [DLY_W-1:0] cnt_q;
    logic [DLY_W-1:0] delay_q, delay_d;
    logic [1:0]       ctrl_q, ctrl_d;
    logic [5:0]       pad_cfg_q, pad_cfg_d;
    logic             pend_q, pend_d;
    logic             ack_q;
    logic [31:0]      dat_q, rdata;
    logic [5:0]       pad_q, pad_d;
    logic [1:0]       bias_q, bias_d;
    logic             ib_q, ib_d, in_q, in_d, ready_q, ready_d, irq_q;

    logic        wb_hit, wb_acc, wb_wr, irq_set, irq_clr, enable, cnt_zero;
    logic [2:0]  idx;
    logic [31:0] wmask, wdat;

    assign wb_hit   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    assign wb_acc   = wb_hit & ~ack_q;
    assign wb_wr    = wb_acc & wbs_we_i;
    assign idx      = wbs_adr_i[4:2];
    assign wmask    = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign wdat     = wbs_dat_i & wmask;
    assign enable   = ctrl_q[0];
    assign cnt_zero = (cnt_q == '0);

`ifdef OPAMP_SEQ_RUNCNT_EN
    logic [31:0] runcnt_q;
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)
            runcnt_q <= '0;
        else if (state_d == S_RUN && state_q != S_RUN)
            runcnt_q <= '0;
        else if (state_q == S_RUN && runcnt_q != 32'hFFFF_FFFF)
            runcnt_q <= runcnt_q + 32'd1;
    end
`endif

    always_comb begin
        ctrl_d    = ctrl_q;
        delay_d   = delay_q;
        pad_cfg_d = pad_cfg_q;
        if (wb_wr) begin
            case (idx)
                3'd0:    ctrl_d    = (ctrl_q & ~wmask[1:0]) | wdat[1:0];
                3'd1:    delay_d   = (delay_q & ~wmask[DLY_W-1:0]) | wdat[DLY_W-1:0];
                3'd3:    pad_cfg_d = (pad_cfg_q & ~wmask[5:0]) | wdat[5:0];
                default: ;
            endcase
        end
        // A completion event in the same cycle as a W1C keeps the flag set.
        irq_set = (state_d == S_RUN && state_q != S_RUN) ||
                  (state_q == S_SD_IB && state_d == S_OFF);
        irq_clr = wb_wr && (idx == 3'd2) && wdat[4];
        pend_d  = irq_set | (pend_q & ~irq_clr);
    end

    always_comb begin
        rdata = '0;
        case (idx)
            3'd0: rdata = {30'd0, ctrl_q};
            3'd1: rdata = 32'(delay_q);
            3'd2: rdata = {27'd0, pend_q, ready_q, state_q};
            3'd3: rdata = {26'd0, pad_cfg_q};
`ifdef OPAMP_SEQ_RUNCNT_EN
            3'd4: rdata = runcnt_q;
`endif
            default: rdata = '0;
        endcase
    end

    // Aborts take priority over the settle timer in the power-up states.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_OFF:     if (enable) state_d = S_ISOLATE;
            S_ISOLATE: if (!enable) state_d = S_OFF;     else if (cnt_zero) state_d = S_BIAS;
            S_BIAS:    if (!enable) state_d = S_OFF;     else if (cnt_zero) state_d = S_CURRENT;
            S_CURRENT: if (!enable) state_d = S_SD_IB;   else if (cnt_zero) state_d = S_INPUTS;
            S_INPUTS:  if (!enable) state_d = S_SD_IN;   else if (cnt_zero) state_d = S_RUN;
            S_RUN:     if (!enable) state_d = S_SD_IN;
            S_SD_IN:   if (cnt_zero) state_d = S_SD_IB;
            S_SD_IB:   if (cnt_zero) state_d = S_OFF;
            default:   state_d = S_OFF;
        endcase
    end

    always_comb begin
        pad_d   = 6'h3F;
        bias_d  = 2'b00;
        ib_d    = 1'b0;
        in_d    = 1'b0;
        ready_d = 1'b0;
        case (state_d)
            S_BIAS:    bias_d = 2'b11;
            S_CURRENT: begin bias_d = 2'b11; ib_d = 1'b1; end
            S_INPUTS:  begin bias_d = 2'b11; ib_d = 1'b1; in_d = 1'b1; end
            S_RUN: begin
                bias_d  = 2'b11;
                ib_d    = 1'b1;
                in_d    = 1'b1;
                pad_d   = pad_cfg_q;
                ready_d = 1'b1;
            end
            S_SD_IN:   begin bias_d = 2'b11; ib_d = 1'b1; end
            S_SD_IB:   bias_d = 2'b11;
            default:   ;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= S_OFF;
            cnt_q     <= '0;
            ctrl_q    <= 2'b00;
            delay_q   <= DEFAULT_DELAY;
            pad_cfg_q <= 6'h3F;
            pend_q    <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            pad_q     <= 6'h3F;
            bias_q    <= 2'b00;
            ib_q      <= 1'b0;
            in_q      <= 1'b0;
            ready_q   <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            // Settle counter reloads from DELAY on every state change.
            if (state_d != state_q)
                cnt_q <= delay_q;
            else if (!cnt_zero)
                cnt_q <= cnt_q - 1'b1;
            ctrl_q    <= ctrl_d;
            delay_q   <= delay_d;
            pad_cfg_q <= pad_cfg_d;
            pend_q    <= pend_d;
            ack_q     <= wb_acc;
            dat_q     <= wb_acc ? rdata : 32'd0;
            pad_q     <= pad_d;
            bias_q    <= bias_d;
            ib_q      <= ib_d;
            in_q      <= in_d;
            ready_q   <= ready_d;
            irq_q     <= pend_d & ctrl_d[1];
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign pad_oeb_o = pad_q;
    assign bias_en_o = bias_q;
    assign ib_en_o   = ib_q;
    assign in_en_o   = in_q;
    assign ready_o   = ready_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_opamp_seq_ctrl.sv
// Scoreboarded bench for opamp_seq_ctrl: bus reads are checked by a monitor,
// sequencer outputs are checked cycle by cycle against the state table.
module tb_opamp_seq_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0100;
    localparam int S_OFF = 0, S_ISO = 1, S_BIAS = 2, S_CUR = 3, S_INP = 4,
                   S_RUN = 5, S_SDIN = 6, S_SDIB = 7;

    logic        clk, rst_n;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic [31:0] dat_o;
    logic        ack_o;
    logic [5:0]  pad_oeb;
    logic [1:0]  bias_en;
    logic        ib_en, in_en, ready, irq;

    int nvec = 0;
    int nerr = 0;
    int run_cyc = 0;
    logic prev_ack = 1'b0;

    typedef struct {
        bit          chk;
        logic [31:0] dat;
        string       nm;
    } sb_t;
    sb_t sbq[$];

    opamp_seq_ctrl dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat),
        .wbs_dat_o (dat_o),
        .wbs_ack_o (ack_o),
        .pad_oeb_o (pad_oeb),
        .bias_en_o (bias_en),
        .ib_en_o   (ib_en),
        .in_en_o   (in_en),
        .ready_o   (ready),
        .irq_o     (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Monitor: every ack consumes one scoreboard entry.
    always @(posedge clk) begin
        sb_t e;
        #1;
        if (ack_o) begin
            if (prev_ack) begin
                nvec++; nerr++;
                $display("FAIL ack_width: ack high two cycles in a row");
            end
            if (sbq.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL unexpected_ack: dat=%h", dat_o);
            end else begin
                e = sbq.pop_front();
                if (e.chk) begin
                    nvec++;
                    if (dat_o !== e.dat) begin
                        nerr++;
                        $display("FAIL %s: got %h expected %h", e.nm, dat_o, e.dat);
                    end
                end
            end
        end else if (prev_ack) begin
            nvec++;
            if (dat_o !== 32'd0) begin
                nerr++;
                $display("FAIL dat_idle: got %h expected 0", dat_o);
            end
        end
        prev_ack = ack_o;
    end

    always @(posedge clk) begin
        #1;
        if (ready) run_cyc++;
    end

    task automatic chk1(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [5:0] p, input logic [1:0] b,
                           input logic i, input logic n, input logic r);
        nvec++;
        if ({pad_oeb, bias_en, ib_en, in_en, ready} !== {p, b, i, n, r}) begin
            nerr++;
            $display("FAIL %s: got pad=%h b=%b i=%b n=%b r=%b expected pad=%h b=%b i=%b n=%b r=%b",
                     nm, pad_oeb, bias_en, ib_en, in_en, ready, p, b, i, n, r);
        end
    endtask

    // Checks n consecutive cycles against the output row of state s.
    task automatic expect_seq(input int s, input int n, input logic [5:0] pcfg, input string nm);
        logic [5:0] p;
        logic [1:0] b;
        logic i, nn, r;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            p = 6'h3F; b = 2'b00; i = 1'b0; nn = 1'b0; r = 1'b0;
            case (s)
                S_BIAS:  b = 2'b11;
                S_CUR:   begin b = 2'b11; i = 1'b1; end
                S_INP:   begin b = 2'b11; i = 1'b1; nn = 1'b1; end
                S_RUN:   begin b = 2'b11; i = 1'b1; nn = 1'b1; p = pcfg; r = 1'b1; end
                S_SDIN:  begin b = 2'b11; i = 1'b1; end
                S_SDIB:  b = 2'b11;
                default: ;
            endcase
            chk_out($sformatf("%s[%0d]", nm, k), p, b, i, nn, r);
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input bit exp_ack, input bit chk,
                           input logic [31:0] exp, input string nm);
        bit got;
        if (exp_ack) sbq.push_back('{chk, exp, nm});
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
        got = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (ack_o) begin got = 1'b1; break; end
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        nvec++;
        if (got != exp_ack) begin
            nerr++;
            $display("FAIL ack_%s: got %0d expected %0d", nm, got, exp_ack);
        end
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        wb_xfer(1'b1, BASE + off, d, 4'hF, 1'b1, 1'b0, 32'd0, $sformatf("wr%0h", off));
    endtask

    task automatic rd(input logic [31:0] off, input logic [31:0] exp, input string nm);
        wb_xfer(1'b0, BASE + off, 32'd0, 4'hF, 1'b1, 1'b1, exp, nm);
    endtask

    task automatic wait_ready(input logic lvl, input string nm);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(posedge clk); #1;
            if (ready == lvl) begin got = 1'b1; break; end
        end
        nvec++;
        if (!got) begin
            nerr++;
            $display("FAIL %s: ready never reached %b", nm, lvl);
        end
    endtask

    task automatic run_window(input int hold, input string nm);
        logic [31:0] exp;
        run_cyc = 0;
        wr(32'h00, 32'h1);
        wait_ready(1'b1, {nm, "_up"});
        repeat (hold) @(posedge clk);
        wr(32'h00, 32'h0);
        wait_ready(1'b0, {nm, "_down"});
`ifdef OPAMP_SEQ_RUNCNT_EN
        exp = run_cyc;
`else
        exp = 32'd0;
`endif
        rd(32'h10, exp, nm);
    endtask

    initial begin
        rst_n = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_out("reset_outs", 6'h3F, 2'b00, 1'b0, 1'b0, 1'b0);
        chk1("reset_irq", {31'd0, irq}, 32'd0);
        chk1("reset_ack", {31'd0, ack_o}, 32'd0);
        chk1("reset_dat", dat_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        rd(32'h00, 32'd0,   "rst_ctrl");
        rd(32'h04, 32'd100, "rst_delay");
        rd(32'h08, 32'd0,   "rst_status");
        rd(32'h0C, 32'h3F,  "rst_padcfg");

        // Power-up with DELAY=2: three cycles per timed state.
        wr(32'h04, 32'd2);
        wr(32'h0C, 32'h15);
        wr(32'h00, 32'h3);
        expect_seq(S_ISO,  3, 6'h15, "up_iso");
        expect_seq(S_BIAS, 3, 6'h15, "up_bias");
        expect_seq(S_CUR,  3, 6'h15, "up_cur");
        expect_seq(S_INP,  3, 6'h15, "up_inp");
        expect_seq(S_RUN,  1, 6'h15, "up_run");
        chk1("run_irq", {31'd0, irq}, 32'd1);
        rd(32'h08, 32'h1D, "run_status");

        // PAD_CFG change in RUN lands on the cycle after its ack.
        wr(32'h0C, 32'h2A);
        expect_seq(S_RUN, 1, 6'h2A, "run_padcfg");

        // W1C then normal shutdown.
        wr(32'h08, 32'h10);
        chk1("w1c_irq", {31'd0, irq}, 32'd0);
        wr(32'h00, 32'h2);
        expect_seq(S_SDIN, 3, 6'h2A, "sd_in");
        expect_seq(S_SDIB, 3, 6'h2A, "sd_ib");
        expect_seq(S_OFF,  1, 6'h2A, "sd_off");
        chk1("sd_irq", {31'd0, irq}, 32'd1);
        wr(32'h08, 32'h10);
        wr(32'h0C, 32'h15);

        // Abort from CURRENT, re-enable during SD_IB, abort from BIAS.
        wr(32'h04, 32'd5);
        wr(32'h00, 32'h3);
        expect_seq(S_ISO,  6, 6'h15, "ab_iso");
        expect_seq(S_BIAS, 6, 6'h15, "ab_bias");
        expect_seq(S_CUR,  2, 6'h15, "ab_cur");
        wr(32'h00, 32'h2);
        expect_seq(S_SDIB, 2, 6'h15, "ab_sdib");
        wr(32'h00, 32'h3);
        expect_seq(S_SDIB, 3, 6'h15, "ab_sdib_hold");
        expect_seq(S_OFF,  1, 6'h15, "ab_off");
        chk1("ab_irq", {31'd0, irq}, 32'd1);
        expect_seq(S_ISO,  6, 6'h15, "re_iso");
        expect_seq(S_BIAS, 1, 6'h15, "re_bias");
        wr(32'h00, 32'h2);
        expect_seq(S_OFF,  1, 6'h15, "bias_abort");
        rd(32'h08, 32'h10, "abort_status");
        wr(32'h08, 32'h10);
        rd(32'h08, 32'h00, "clr_status");

        // Bus decode and byte enables.
        wb_xfer(1'b1, 32'h3000_0200, 32'h0, 4'hF, 1'b0, 1'b0, 32'd0, "out_of_window");
        wb_xfer(1'b1, BASE + 32'h0C, 32'h3F, 4'h0, 1'b1, 1'b0, 32'd0, "sel_none");
        rd(32'h0C, 32'h15, "padcfg_kept");
        wb_xfer(1'b1, BASE + 32'h04, 32'h0000_0300, 4'b0010, 1'b1, 1'b0, 32'd0, "sel_byte1");
        rd(32'h04, 32'h305, "delay_byte1");
        wr(32'h14, 32'hFFFF_FFFF);
        rd(32'h14, 32'd0, "unmapped");

        // RUN-time counter: a long window, then a short one after re-entry.
        wr(32'h04, 32'd0);
        run_window(9, "runcnt_a");
        run_window(3, "runcnt_b");

        // Asynchronous reset in the middle of RUN.
        wr(32'h00, 32'h3);
        wait_ready(1'b1, "pre_reset_run");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_reset", 6'h3F, 2'b00, 1'b0, 1'b0, 1'b0);
        chk1("async_reset_irq", {31'd0, irq}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd(32'h0C, 32'h3F, "post_rst_pad");
        rd(32'h04, 32'd100, "post_rst_delay");
        rd(32'h00, 32'd0, "post_rst_ctrl");

        repeat (3) @(posedge clk);
        #1;
        chk1("sb_drained", sbq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/opamp_seq_ctrl.md
Name: opamp_seq_ctrl

Overview:
- Wishbone-slave power sequencer for the cascode opamp and its analog pad group (user pads 12..17).
- Brings the amplifier up in a fixed order with a programmable settle time per step: isolate pads, bias, tail current, inputs, release pads.
- Tears it down in reverse order.
- Drives the analog pad io_oeb bits and the opamp/switch enable nets; raises a user IRQ when power-up or shutdown completes.

Parameters:
- BASE_ADDR, 32'h3000_0100, Wishbone base address, 32-byte aligned.
- DLY_W, 16, width of the settle counter and DELAY register.
- DEFAULT_DELAY, 16'd100, DELAY reset value in clock cycles.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_ni  in  1  asynchronous active-low reset
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte enables
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_dat_o  out  32  read data
- wbs_ack_o  out  1  acknowledge
- pad_oeb_o  out  6  io_oeb for pads 17..12 (1 = tristate)
- bias_en_o  out  2  VB_B, VB_A bias enables
- ib_en_o  out  1  tail-current (IB) enable
- in_en_o  out  1  IN_P/IN_M input switch enable
- ready_o  out  1  opamp in RUN
- irq_o  out  1  interrupt, level

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset is asynchronous and active-low on wb_rst_ni.
- Reset values: pad_oeb_o=6'h3F; bias_en_o=0; ib_en_o=0; in_en_o=0; ready_o=0; irq_o=0; wbs_ack_o=0; wbs_dat_o=0; FSM=OFF; registers at the reset values below.
- Wishbone:
  - Selected when cyc&stb and adr[31:5]==BASE_ADDR[31:5].
  - Register index = adr[4:2].
  - wbs_ack_o is asserted the cycle after selection, for one cycle only: ack <= sel & ~ack.
  - wbs_dat_o is registered with the ack and is 0 when ack is low.
  - Writes honour wbs_sel_i per byte.
  - Unmapped indices read 0, ignore writes and are still acked.
  - Addresses outside the window are never acked.
- Registers:
  - 0x00 CTRL (rw, reset 0): bit0 ENABLE, bit1 IRQ_EN.
  - 0x04 DELAY (rw, reset DEFAULT_DELAY): [DLY_W-1:0].
  - 0x08 STATUS: [2:0] state code (ro); bit3 ready (ro); bit4 IRQ_PEND (write 1 to clear).
  - 0x0C PAD_CFG (rw, reset 6'h3F): [5:0] oeb value applied in RUN.
- FSM state codes and outputs (b = bias_en_o, i = ib_en_o, n = in_en_o):
  - OFF=0, ISOLATE=1: b=00, i=0, n=0.
  - BIAS=2: b=11.
  - CURRENT=3: b=11, i=1.
  - INPUTS=4: b=11, i=1, n=1.
  - RUN=5: as INPUTS, plus pad_oeb_o=PAD_CFG and ready_o=1.
  - SD_IN=6: b=11, i=1, n=0.
  - SD_IB=7: b=11, i=0, n=0.
  - pad_oeb_o=6'h3F in every state except RUN.
  - All outputs are registered from the next-state logic, so they change in the same cycle the state register changes.
- Dwell:
  - The counter loads DELAY on every state entry.
  - The state advances when counter==0, giving a dwell of DELAY+1 cycles.
  - Timed states: ISOLATE, BIAS, CURRENT, INPUTS, SD_IN, SD_IB.
  - A DELAY write takes effect at the next state entry only.
- Transitions:
  - Power-up: OFF -> ISOLATE when ENABLE=1, then ISOLATE -> BIAS -> CURRENT -> INPUTS -> RUN.
  - RUN holds while ENABLE=1.
  - Normal shutdown (ENABLE=0 in RUN or INPUTS): -> SD_IN -> SD_IB -> OFF.
  - Abort (ENABLE=0): from CURRENT -> SD_IB; from BIAS or ISOLATE -> OFF on the next cycle.
  - ENABLE=1 during SD_IN/SD_IB is ignored until OFF is reached; the sequence then restarts from ISOLATE.
- IRQ:
  - IRQ_PEND is set on entry to RUN and on entry to OFF from SD_IB.
  - irq_o = IRQ_PEND & IRQ_EN.
  - A W1C in the same cycle as a set event leaves IRQ_PEND set (set wins).
- PAD_CFG written while in RUN: pad_oeb_o updates the cycle after the write ack.
- Reset asserted mid-sequence: all outputs go to their reset values immediately (asynchronously).

Optional Feature:
- Macro: OPAMP_SEQ_RUNCNT_EN.
- Defined:
  - Index 4 (0x10) is RUNCNT, read-only, 32 bits.
  - Cleared on entry to RUN; increments every cycle in RUN; saturates at 32'hFFFF_FFFF.
  - Holds its value after leaving RUN; reset value 0.
- Not defined: 0x10 reads 0 and is acked; no counter logic is present.

Test Plan:
- Reset, then read 0x00/0x04/0x08/0x0C -> 0, 100, 0, 0x3F; each ack is exactly one cycle; outputs at reset values.
- DELAY=2, PAD_CFG=0x15, CTRL=0x3 -> 3 cycles in each of ISOLATE/BIAS/CURRENT/INPUTS; RUN entered 12 cycles after CTRL is set; pad_oeb_o=0x15; ready_o=1; irq_o=1.
- In RUN, write STATUS bit4=1 -> irq_o=0; write CTRL=0x2 -> pad_oeb_o=0x3F and in_en_o=0 next cycle, 3 cycles SD_IN, 3 cycles SD_IB, then OFF with irq_o=1.
- DELAY=5; clear ENABLE during CURRENT -> SD_IB for 6 cycles then OFF; ib_en_o drops immediately; set ENABLE during SD_IB -> restart from ISOLATE only after OFF.
- Write to 0x3000_0200, and to 0x0C with sel=4'b0000 -> first gets no ack; second is acked and PAD_CFG is unchanged.
- OPAMP_SEQ_RUNCNT_EN defined, DELAY=0: dwell 10 cycles in RUN -> RUNCNT=10; re-entering RUN clears it.
